// File: rtl/hough_pkg.sv
// Shared constants and FSM state type for the Hough pixel streamer and hough_acc.
package hough_pkg;
  localparam int ROW_LENGTH  = 600;
  localparam int COL_LENGTH  = 400;
  localparam int COL_BIAS    = 20;
  localparam int ROW_BIAS    = 40;
  localparam int RADIUS      = 200;
  localparam int EDGE_THRESH = 1;
  localparam int X_W         = 10;
  localparam int Y_W         = 9;
  localparam int PIX_W       = 4;
  localparam int FB_ADDR_W   = 18;
  localparam int EC_W        = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } hough_state_e;
endpackage

// File: rtl/hough_pixel_streamer_if.sv
// Frame-buffer read port plus the (X, Y, pixel) stream toward hough_acc.
interface hough_pixel_streamer_if
  import hough_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
);
    // Read port: fb_rd_data is valid the cycle after the edge that samples fb_rd_en/fb_addr.
    // Pixel stream: valid-only (no ready); the consumer must take every out_valid beat.
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_rd_data;
    logic [X_W-1:0]    X;
    logic [Y_W-1:0]    Y;
    logic [PIX_W-1:0]  pixel;
    logic              out_valid;

    modport master (
        output fb_rd_en, fb_addr, X, Y, pixel, out_valid,
        input  fb_rd_data
    );

    modport slave (
        input  fb_rd_en, fb_addr, X, Y, pixel, out_valid,
        output fb_rd_data
    );
endinterface

// File: rtl/hough_raster_ctr.sv
// Raster column/row/address counters; stops on the last ROI pixel instead of wrapping.
module hough_raster_ctr
  import hough_pkg::*;
#(
    parameter int ROW_LENGTH = hough_pkg::ROW_LENGTH,
    parameter int COL_LENGTH = hough_pkg::COL_LENGTH,
    parameter int ADDR_W     = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              adv_i,
    output logic [X_W-1:0]    col_o,
    output logic [Y_W-1:0]    row_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    logic [X_W-1:0]    col_q, col_d;
    logic [Y_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last;

    assign last = (col_q == X_W'(ROW_LENGTH - 1)) && (row_q == Y_W'(COL_LENGTH - 1));

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clear_i) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (adv_i && !last) begin
            // Address is a running count, so no row*ROW_LENGTH multiply is needed.
            addr_d = addr_q + 1'b1;
            if (col_q == X_W'(ROW_LENGTH - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign addr_o = addr_q;
    assign last_o = last;
endmodule

// File: rtl/hough_pixel_streamer.sv
// Scans the edge-map frame buffer over the ROI once per start and streams (X, Y, pixel).
module hough_pixel_streamer
  import hough_pkg::*;
#(
    parameter int ROW_LENGTH  = hough_pkg::ROW_LENGTH,
    parameter int COL_LENGTH  = hough_pkg::COL_LENGTH,
    parameter int COL_BIAS    = hough_pkg::COL_BIAS,
    parameter int ROW_BIAS    = hough_pkg::ROW_BIAS,
    parameter int EDGE_THRESH = hough_pkg::EDGE_THRESH,
    parameter int ADDR_W      = FB_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  en,
    hough_pixel_streamer_if.master px,
    output logic                  busy,
    output logic                  done,
    output logic [EC_W-1:0]       edge_count,
    output hough_state_e          state_o
);
    hough_state_e      state_q, state_d;
    logic [1:0]        drain_cnt_q, drain_cnt_d;
    logic              issue, ctr_clear, last;
    logic [X_W-1:0]    col;
    logic [Y_W-1:0]    row;
    logic [ADDR_W-1:0] addr;

    logic              rd_en_q, s2_valid_q, out_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [X_W-1:0]    s1_col_q, s2_col_q, x_q;
    logic [Y_W-1:0]    s1_row_q, s2_row_q, y_q;
    logic [PIX_W-1:0]  pixel_q, pixel_d;
    logic [EC_W-1:0]   edge_cnt_q;

    hough_raster_ctr #(
        .ROW_LENGTH(ROW_LENGTH),
        .COL_LENGTH(COL_LENGTH),
        .ADDR_W    (ADDR_W)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(ctr_clear),
        .adv_i  (issue),
        .col_o  (col),
        .row_o  (row),
        .addr_o (addr),
        .last_o (last)
    );

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        issue       = 1'b0;
        ctr_clear   = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d   = ST_SCAN;
                ctr_clear = 1'b1;
            end
            ST_SCAN: if (en) begin
                issue = 1'b1;
                if (last) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            // Hold until the last read has reached the output registers.
            ST_DRAIN: if (drain_cnt_q == 2'd2) state_d = ST_DONE;
                      else drain_cnt_d = drain_cnt_q + 1'b1;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign pixel_d = (s2_valid_q && (int'(px.fb_rd_data) >= EDGE_THRESH)) ? px.fb_rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_col_q    <= '0;
            s2_row_q    <= '0;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pixel_q     <= '0;
            edge_cnt_q  <= '0;
        end else begin
            rd_en_q <= issue;
            if (issue) begin
                addr_q   <= addr;
                s1_col_q <= col;
                s1_row_q <= row;
            end
            s2_valid_q <= rd_en_q;
            if (rd_en_q) begin
                s2_col_q <= s1_col_q;
                s2_row_q <= s1_row_q;
            end
            out_valid_q <= s2_valid_q;
            pixel_q     <= pixel_d;
            if (s2_valid_q) begin
                x_q <= s2_col_q + X_W'(COL_BIAS);
                y_q <= s2_row_q + Y_W'(ROW_BIAS);
            end
            if (ctr_clear) edge_cnt_q <= '0;
            else if ((pixel_d != '0) && (edge_cnt_q != '1)) edge_cnt_q <= edge_cnt_q + 1'b1;
        end
    end

    assign px.fb_rd_en  = rd_en_q;
    assign px.fb_addr   = addr_q;
    assign px.X         = x_q;
    assign px.Y         = y_q;
    assign px.pixel     = pixel_q;
    assign px.out_valid = out_valid_q;
    assign busy         = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign edge_count   = edge_cnt_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_hough_pixel_streamer.sv
// Directed bench for hough_pixel_streamer on a 6x4 ROI, with threshold 1 and threshold 4 copies.
module tb_hough_pixel_streamer;
  import hough_pkg::*;

  localparam int RL   = 6;
  localparam int CL   = 4;
  localparam int NPIX = RL * CL;
  localparam int AW   = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  hough_pixel_streamer_if #(.ADDR_W(AW)) px1 ();
  hough_pixel_streamer_if #(.ADDR_W(AW)) px4 ();
  logic busy1, done1, busy4, done4;
  logic [EC_W-1:0] ec1, ec4;
  hough_state_e st1, st4;

  hough_pixel_streamer #(.ROW_LENGTH(RL), .COL_LENGTH(CL), .COL_BIAS(20), .ROW_BIAS(40),
    .EDGE_THRESH(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .px(px1),
    .busy(busy1), .done(done1), .edge_count(ec1), .state_o(st1));

  hough_pixel_streamer #(.ROW_LENGTH(RL), .COL_LENGTH(CL), .COL_BIAS(20), .ROW_BIAS(40),
    .EDGE_THRESH(4), .ADDR_W(AW)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .px(px4),
    .busy(busy4), .done(done4), .edge_count(ec4), .state_o(st4));

  // Frame buffer: one-cycle registered read
  logic [3:0] mem [32];
  initial begin
    px1.fb_rd_data = '0;
    px4.fb_rd_data = '0;
  end
  always @(posedge clk) if (px1.fb_rd_en) px1.fb_rd_data <= mem[px1.fb_addr[4:0]];
  always @(posedge clk) if (px4.fb_rd_en) px4.fb_rd_data <= mem[px4.fb_addr[4:0]];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [22:0] exp1_q[$];
  logic [22:0] exp4_q[$];
  int exp_ec1, exp_ec4;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_expected();
    int x, y, v;
    exp1_q.delete();
    exp4_q.delete();
    exp_ec1 = 0;
    exp_ec4 = 0;
    for (int a = 0; a < NPIX; a++) begin
      x = 20 + a % RL;
      y = 40 + a / RL;
      v = int'(mem[a]);
      exp1_q.push_back({10'(x), 9'(y), 4'(v >= 1 ? v : 0)});
      exp4_q.push_back({10'(x), 9'(y), 4'(v >= 4 ? v : 0)});
      if (v >= 1) exp_ec1++;
      if (v >= 4) exp_ec4++;
    end
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  bit mon_on = 1'b0;
  int cyc = 0;
  int nval1, first_rd, first_ov, last_ov, done_cyc, ndone, exp_addr;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_on) begin
      if (px1.fb_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        check_val("fb_addr", 32'(px1.fb_addr), 32'(exp_addr));
        exp_addr++;
      end
      if (px1.out_valid) begin
        nval1++;
        if (first_ov < 0) first_ov = cyc;
        last_ov = cyc;
        if (exp1_q.size() == 0) check_val("dut1_extra_pixel", 32'(1), 32'(0));
        else check_val("dut1_xyp", 32'({px1.X, px1.Y, px1.pixel}), 32'(exp1_q.pop_front()));
      end else begin
        check_val("dut1_pixel_idle", 32'(px1.pixel), 32'(0));
      end
      if (px4.out_valid) begin
        if (exp4_q.size() == 0) check_val("dut4_extra_pixel", 32'(1), 32'(0));
        else check_val("dut4_xyp", 32'({px4.X, px4.Y, px4.pixel}), 32'(exp4_q.pop_front()));
      end
      if (done1) begin
        ndone++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_frame(input string tag, input int en_pct);
    bit got_done = 1'b0;
    load_expected();
    nval1 = 0; first_rd = -1; first_ov = -1; last_ov = -1;
    done_cyc = -1; ndone = 0; exp_addr = 0;
    mon_on = 1'b1;
    @(posedge clk); #1 start = 1'b1; en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (done1) begin
        // start during the DONE cycle must not launch another frame
        start = 1'b1;
        got_done = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        break;
      end
      start = (i == 5);
      en = ($urandom_range(0, 99) < en_pct);
    end
    start = 1'b0;
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    mon_on = 1'b0;
    check_val({tag, "_done_seen"}, 32'(got_done), 32'(1));
    check_val({tag, "_valid_count"}, 32'(nval1), 32'(NPIX));
    check_val({tag, "_q1_left"}, 32'(exp1_q.size()), 32'(0));
    check_val({tag, "_q4_left"}, 32'(exp4_q.size()), 32'(0));
    check_val({tag, "_addr_count"}, 32'(exp_addr), 32'(NPIX));
    check_val({tag, "_done_pulses"}, 32'(ndone), 32'(1));
    check_val({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_ov + 1));
    check_val({tag, "_edge_count1"}, 32'(ec1), 32'(exp_ec1));
    check_val({tag, "_edge_count4"}, 32'(ec4), 32'(exp_ec4));
    check_val({tag, "_busy_low"}, 32'(busy1), 32'(0));
    check_val({tag, "_state_idle"}, 32'(st1), 32'(ST_IDLE));
    if (en_pct == 100) check_val({tag, "_latency"}, 32'(first_ov - first_rd), 32'(2));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int a = 0; a < 32; a++) mem[a] = 4'(a);
    do_reset();
    #1;
    check_val("rst_out_valid", 32'(px1.out_valid), 32'(0));
    check_val("rst_fb_rd_en", 32'(px1.fb_rd_en), 32'(0));
    check_val("rst_xy", 32'({px1.X, px1.Y}), 32'(0));
    check_val("rst_busy_done", 32'({busy1, done1}), 32'(0));
    check_val("rst_edge_count", 32'(ec1), 32'(0));
    check_val("rst_state", 32'(st1), 32'(ST_IDLE));

    // addr[3:0] pattern: 0 and 16 are the only zero pixels; >=4 holds for 4..15 and 20..23
    run_frame("ramp", 100);
    check_val("ramp_ec1_hand", 32'(ec1), 32'(22));
    check_val("ramp_ec4_hand", 32'(ec4), 32'(16));

    for (int a = 0; a < 32; a++) mem[a] = 4'd0;
    mem[RL] = 4'd9;
    run_frame("single", 100);
    check_val("single_ec1_hand", 32'(ec1), 32'(1));

    for (int a = 0; a < 32; a++) mem[a] = 4'(a);
    run_frame("en_rand", 50);

    for (int a = 0; a < 32; a++) mem[a] = (a % 2 == 0) ? 4'd3 : 4'd4;
    run_frame("thresh", 100);
    check_val("thresh_ec4_hand", 32'(ec4), 32'(12));
    check_val("thresh_ec1_hand", 32'(ec1), 32'(24));

    // Reset in the middle of row 2, then a clean rescan from (20,40)
    begin
      bit hit = 1'b0;
      bit saw_done = 1'b0;
      for (int a = 0; a < 32; a++) mem[a] = 4'(a + 1);
      @(posedge clk); #1 start = 1'b1; en = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (px1.fb_rd_en && px1.fb_addr == AW'(2 * RL + 2)) begin
          hit = 1'b1;
          break;
        end
      end
      check_val("midrst_reached_row2", 32'(hit), 32'(1));
      check_val("midrst_valid_before", 32'(px1.out_valid), 32'(1));
      #1 rst_n = 1'b0;
      #1;
      check_val("midrst_out_valid", 32'(px1.out_valid), 32'(0));
      check_val("midrst_rd_en", 32'(px1.fb_rd_en), 32'(0));
      check_val("midrst_xyp", 32'({px1.X, px1.Y, px1.pixel}), 32'(0));
      check_val("midrst_edge_count", 32'(ec1), 32'(0));
      check_val("midrst_busy", 32'(busy1), 32'(0));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (done1) saw_done = 1'b1;
      end
      check_val("midrst_no_done", 32'(saw_done), 32'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      run_frame("after_rst", 100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end
endmodule
